// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Fetch-stage constants and the fetch FSM state encoding.
package mips_pkg;

   localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
   localparam int unsigned PC_STEP        = 4;
   localparam logic [31:0] HALT_WORD_DFLT = 32'hFFFF_FFFF;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux for the fetch stage.
// Purely combinational; drives pc.In.
module next_pc_sel
   import mips_pkg::*;
#(
   parameter int len = 32
) (
   input  logic           reset,
   input  logic           enable,
   input  logic           halted,
   input  logic           stall,
   input  logic           branch_taken,
   input  logic [len-1:0] branch_target,
   input  logic           jump,
   input  logic [len-1:0] jump_target,
   input  logic [len-1:0] pc_in,
   output logic [len-1:0] next_pc
);

   logic [len-1:0] w_pc_plus4;

   // Wraps silently modulo 2^len.
   assign w_pc_plus4 = pc_in + len'(PC_STEP);

   always_comb begin
      next_pc = w_pc_plus4;
      if (!reset)
         next_pc = '0;
      else if (!enable)
         next_pc = pc_in;
      else if (branch_taken)
         next_pc = branch_target;
      else if (jump)
         next_pc = jump_target;
      else if (stall || halted)
         next_pc = pc_in;
   end

endmodule

// File: rtl/if_id_fetch.sv
// MIPS instruction-fetch stage: IF/ID register and halt FSM.
// Resolves redirects, stalls and debug single-step.
module if_id_fetch
   import mips_pkg::*;
#(
   parameter int             len       = 32,
   parameter logic [len-1:0] HALT_WORD = len'(HALT_WORD_DFLT)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [len-1:0] pc_in,
   input  logic [len-1:0] instr_in,
   input  logic           stall,
   input  logic           branch_taken,
   input  logic [len-1:0] branch_target,
   input  logic           jump,
   input  logic [len-1:0] jump_target,
   output logic [len-1:0] next_pc,
   output logic [len-1:0] instr_out,
   output logic [len-1:0] pc_plus4_out,
   output logic           valid_out,
   output logic           halt_out
);

   localparam logic [len-1:0] W_NOP = len'(NOP_WORD);

   fetch_state_t   r_state;
   logic [len-1:0] r_instr;
   logic [len-1:0] r_pc4;
   logic           r_valid;

   fetch_state_t   w_state_nxt;
   logic [len-1:0] w_instr_nxt;
   logic [len-1:0] w_pc4_nxt;
   logic           w_valid_nxt;
   logic           w_redirect;
   logic           w_halted;

   assign w_redirect = branch_taken | jump;
   assign w_halted   = (r_state == HALTED);

   next_pc_sel #(
      .len (len)
   ) u_next_pc_sel (
      .reset         (reset),
      .enable        (enable),
      .halted        (w_halted),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc_in         (pc_in),
      .next_pc       (next_pc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_instr_nxt = r_instr;
      w_pc4_nxt   = r_pc4;
      w_valid_nxt = r_valid;
      if (enable) begin
         if (w_redirect) begin
            // Redirect cancels any wrong-path halt.
            w_state_nxt = RUN;
            w_instr_nxt = W_NOP;
            w_pc4_nxt   = '0;
            w_valid_nxt = 1'b0;
         end else if (stall) begin
            w_state_nxt = r_state;
         end else if (w_halted) begin
            w_instr_nxt = W_NOP;
            w_pc4_nxt   = '0;
            w_valid_nxt = 1'b0;
         end else begin
            w_instr_nxt = instr_in;
            w_pc4_nxt   = pc_in + len'(PC_STEP);
            w_valid_nxt = 1'b1;
            if (instr_in == HALT_WORD)
               w_state_nxt = HALTED;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_instr <= W_NOP;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_instr <= w_instr_nxt;
         r_pc4   <= w_pc4_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign instr_out    = r_instr;
   assign pc_plus4_out = r_pc4;
   assign valid_out    = r_valid;
   assign halt_out     = w_halted;

endmodule

// File: tb/tb_if_id_fetch.sv
// Self-checking bench for if_id_fetch.
// Vector table with a scoreboard queue of expected IF/ID contents.
module tb_if_id_fetch;

   typedef struct {
      logic        en;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        st;
      logic        br;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic [31:0] npc;
      logic [31:0] oi;
      logic [31:0] op;
      logic        ov;
      logic        oh;
   } vec_t;

   typedef struct {
      logic [31:0] oi;
      logic [31:0] op;
      logic        ov;
      logic        oh;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic [31:0] instr_out;
   logic [31:0] pc_plus4_out;
   logic        valid_out;
   logic        halt_out;

   int   tests;
   int   fails;
   vec_t vecs[$];
   exp_t sb[$];

   if_id_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .pc_in         (pc_in),
      .instr_in      (instr_in),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .next_pc       (next_pc),
      .instr_out     (instr_out),
      .pc_plus4_out  (pc_plus4_out),
      .valid_out     (valid_out),
      .halt_out      (halt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic en, input logic [31:0] pc, input logic [31:0] ins,
      input logic st, input logic br, input logic [31:0] bt,
      input logic j, input logic [31:0] jt, input logic [31:0] npc,
      input logic [31:0] oi, input logic [31:0] op,
      input logic ov, input logic oh);
      vec_t v;
      v.en = en; v.pc = pc; v.ins = ins; v.st = st;
      v.br = br; v.bt = bt; v.j = j; v.jt = jt;
      v.npc = npc; v.oi = oi; v.op = op; v.ov = ov; v.oh = oh;
      return v;
   endfunction

   task automatic step(input vec_t v, input int idx);
      exp_t e;
      enable        = v.en;
      pc_in         = v.pc;
      instr_in      = v.ins;
      stall         = v.st;
      branch_taken  = v.br;
      branch_target = v.bt;
      jump          = v.j;
      jump_target   = v.jt;
      #1;
      chk("next_pc", idx, next_pc, v.npc);
      e.oi = v.oi; e.op = v.op; e.ov = v.ov; e.oh = v.oh;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard[%0d]: got empty, want entry", idx);
      end else begin
         e = sb.pop_front();
         chk("instr_out", idx, instr_out, e.oi);
         chk("pc_plus4_out", idx, pc_plus4_out, e.op);
         chk("valid_out", idx, {31'b0, valid_out}, {31'b0, e.ov});
         chk("halt_out", idx, {31'b0, halt_out}, {31'b0, e.oh});
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      // en pc ins st br bt j jt | npc oi op ov oh
      vecs.push_back(mk(1, 32'h00, 32'h2001_0005, 0, 0, 0, 0, 0,
                        32'h04, 32'h2001_0005, 32'h04, 1, 0));
      vecs.push_back(mk(1, 32'h04, 32'h8C22_0000, 0, 0, 0, 0, 0,
                        32'h08, 32'h8C22_0000, 32'h08, 1, 0));
      vecs.push_back(mk(1, 32'h10, 32'h0043_0820, 1, 0, 0, 0, 0,
                        32'h10, 32'h8C22_0000, 32'h08, 1, 0));
      vecs.push_back(mk(1, 32'h10, 32'h0043_0820, 0, 0, 0, 0, 0,
                        32'h14, 32'h0043_0820, 32'h14, 1, 0));
      vecs.push_back(mk(1, 32'h14, 32'hAAAA_AAAA, 1, 1, 32'h40, 1, 32'h80,
                        32'h40, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(1, 32'h40, 32'h1111_1111, 0, 0, 0, 0, 0,
                        32'h44, 32'h1111_1111, 32'h44, 1, 0));
      vecs.push_back(mk(1, 32'h44, 32'hBBBB_BBBB, 0, 0, 0, 1, 32'h1C,
                        32'h1C, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(1, 32'h20, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                        32'h24, 32'hFFFF_FFFF, 32'h24, 1, 1));
      vecs.push_back(mk(1, 32'h24, 32'h1234_5678, 0, 0, 0, 0, 0,
                        32'h24, 32'h0, 32'h0, 0, 1));
      vecs.push_back(mk(1, 32'h24, 32'h1234_5678, 1, 0, 0, 0, 0,
                        32'h24, 32'h0, 32'h0, 0, 1));
      vecs.push_back(mk(1, 32'h24, 32'h1234_5678, 0, 0, 0, 0, 0,
                        32'h24, 32'h0, 32'h0, 0, 1));
      vecs.push_back(mk(1, 32'h24, 32'h1234_5678, 0, 1, 32'h60, 0, 0,
                        32'h60, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(1, 32'h60, 32'h2222_2222, 0, 0, 0, 0, 0,
                        32'h64, 32'h2222_2222, 32'h64, 1, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 32'h64, 32'h3333_3333, 0, 1, 32'h100, 1,
                           32'h200, 32'h64, 32'h2222_2222, 32'h64, 1, 0));
      vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'h4444_4444, 0, 0, 0, 0, 0,
                        32'h0, 32'h4444_4444, 32'h0, 1, 0));
      vecs.push_back(mk(1, 32'h00, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                        32'h04, 32'hFFFF_FFFF, 32'h04, 1, 1));
      vecs.push_back(mk(0, 32'h04, 32'h5555_5555, 0, 0, 0, 0, 0,
                        32'h04, 32'hFFFF_FFFF, 32'h04, 1, 1));

      reset         = 1'b0;
      enable        = 1'b1;
      pc_in         = 32'h8;
      instr_in      = 32'h2001_0005;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      jump          = 1'b0;
      jump_target   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_next_pc", 0, next_pc, 32'h0);
      chk("rst_instr", 0, instr_out, 32'h0);
      chk("rst_pc4", 0, pc_plus4_out, 32'h0);
      chk("rst_valid", 0, {31'b0, valid_out}, 32'h0);
      chk("rst_halt", 0, {31'b0, halt_out}, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], i);

      // Asynchronous reset pulse while HALTED, between edges.
      #3;
      reset = 1'b0;
      #1;
      chk("arst_instr", 100, instr_out, 32'h0);
      chk("arst_pc4", 100, pc_plus4_out, 32'h0);
      chk("arst_valid", 100, {31'b0, valid_out}, 32'h0);
      chk("arst_halt", 100, {31'b0, halt_out}, 32'h0);
      chk("arst_next_pc", 100, next_pc, 32'h0);
      #1;
      reset = 1'b1;

      step(mk(1, 32'h00, 32'h2001_0005, 0, 0, 0, 0, 0,
              32'h04, 32'h2001_0005, 32'h04, 1, 0), 101);
      // Halt word on the wrong path is squashed by the redirect.
      step(mk(1, 32'h04, 32'hFFFF_FFFF, 0, 1, 32'h30, 0, 0,
              32'h30, 32'h0, 32'h0, 0, 0), 102);
      step(mk(1, 32'h30, 32'h5555_5555, 0, 0, 0, 0, 0,
              32'h34, 32'h5555_5555, 32'h34, 1, 0), 103);
      // Jump alone while stalled still redirects.
      step(mk(1, 32'h34, 32'h6666_6666, 1, 0, 0, 1, 32'h90,
              32'h90, 32'h0, 32'h0, 0, 0), 104);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_id_fetch.md
# if_id_fetch

Instruction-fetch stage of the MIPS pipeline, sitting directly downstream of the `pc` register. It consumes the current PC and the instruction word read from instruction memory, and computes the next PC fed back to `pc.In`. It holds the IF/ID pipeline register and a two-state halt controller. Redirects, stalls and debug single-stepping are resolved here.

## Interface
- `len`, 32, data/address width.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that halts fetch.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  debug step enable; low freezes the stage.
- `pc_in`  in  len  current PC from `pc.Out`.
- `instr_in`  in  len  instruction memory word at `pc_in`, combinational read, same cycle.
- `stall`  in  1  load-use hazard hold from the hazard unit.
- `branch_taken`  in  1  EX-stage branch resolved taken.
- `branch_target`  in  len  EX-stage branch target.
- `jump`  in  1  ID-stage jump decoded.
- `jump_target`  in  len  ID-stage jump target.
- `next_pc`  out  len  combinational; drives `pc.In`.
- `instr_out`  out  len  IF/ID instruction.
- `pc_plus4_out`  out  len  IF/ID PC+4.
- `valid_out`  out  1  IF/ID holds a real instruction.
- `halt_out`  out  1  fetch is halted.

## Operation
- States: RUN, HALTED. `halt_out` = (state == HALTED).
- Redirect = `branch_taken | jump`. When both are asserted, `branch_taken` wins because it belongs to the older instruction.
- `next_pc` priority, first match wins:
  1. `reset` low: 0.
  2. `enable` low: `pc_in`.
  3. `branch_taken`: `branch_target`.
  4. `jump`: `jump_target`.
  5. `stall` or HALTED: `pc_in`.
  6. Otherwise: `pc_in + 4`.
- PC+4 is computed modulo 2^len. 32'hFFFF_FFFC wraps to 0 with no flag.
- IF/ID update at a clock edge with `enable` high, first match wins:
  1. Redirect: load bubble (`instr_out` = 0 (NOP), `pc_plus4_out` = 0, `valid_out` = 0). State goes to RUN, cancelling a wrong-path halt.
  2. `stall`: hold all IF/ID contents and state.
  3. HALTED: load bubble and stay HALTED.
  4. RUN: load `instr_in`, `pc_in+4` and `valid_out` = 1. If `instr_in` == `HALT_WORD`, go to HALTED. The halt word itself is passed into ID as valid.
- With `enable` low, IF/ID contents and state hold regardless of the other inputs.
- HALTED exits only via reset or a redirect.

## Timing
- Reset (`reset` low, asynchronous): `instr_out` = 0, `pc_plus4_out` = 0, `valid_out` = 0, state RUN, `halt_out` = 0.
- Reset deassertion takes effect at the first rising edge with `reset` high.
- `next_pc` has zero latency: it is a combinational function of the current inputs and state.
- IF/ID latency is one cycle: the instruction fetched in cycle N appears on `instr_out` in cycle N+1.
- A redirect in cycle N:
  - the target is presented on `next_pc` in cycle N;
  - the wrong-path instruction is dropped and a bubble appears in cycle N+1;
  - the target instruction appears in cycle N+2.
- `halt_out` rises in the cycle after the halt word is fetched, together with the halt word on `instr_out`.
- `stall` and redirect asserted in the same cycle: the redirect wins.
- Reset asserted mid-operation clears everything immediately, including HALTED.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_WORD` = 32'h0;
  - `PC_STEP` = 4;
  - the default `HALT_WORD`;
  - the `fetch_state_t` encoding (RUN = 0, HALTED = 1).
- One sub-module, `next_pc_sel`: the combinational priority mux for `next_pc`.
- The top-level module holds the IF/ID register and the state FSM.

## Test plan
- Reset/sequential fetch: hold `reset` low, then release with `pc_in` = 0x0 and `instr_in` = 0x2001_0005.
  - Required: `next_pc` = 0x4.
  - Next cycle: `instr_out` = 0x2001_0005, `pc_plus4_out` = 0x4, `valid_out` = 1.
- Stall: `stall` = 1 with `pc_in` = 0x10.
  - Required: `next_pc` = 0x10, IF/ID unchanged.
  - Release `stall`: IF/ID loads the PC 0x10 instruction with `pc_plus4_out` = 0x14.
- Redirect priority: `branch_taken` = 1 (`branch_target` = 0x40), `jump` = 1 (`jump_target` = 0x80) and `stall` = 1 together.
  - Required: `next_pc` = 0x40.
  - Next cycle: `valid_out` = 0, `instr_out` = 0.
- Halt: `instr_in` = 0xFFFF_FFFF at `pc_in` = 0x20.
  - Next cycle: `halt_out` = 1, `instr_out` = 0xFFFF_FFFF, `valid_out` = 1.
  - Following cycles: `next_pc` = `pc_in`, `valid_out` = 0.
  - Then `branch_taken` = 1 (target 0x60): `halt_out` drops and `next_pc` = 0x60.
- Debug freeze and wrap:
  - `enable` = 0 for 3 cycles: all outputs hold and `next_pc` = `pc_in`.
  - With `pc_in` = 0xFFFF_FFFC: `next_pc` = 0x0.
  - Async reset pulse mid-cycle while HALTED: outputs clear immediately and `halt_out` = 0.
